branch_target_buffer: RTL

//  Direct-mapped BTB with 2-bit saturating direction counters. Sits directly upstream of the fetch stage.

---
 rtl/branch_target_buffer_pkg.sv | 35 +++
 rtl/branch_target_buffer_if.sv | 32 +++
 rtl/branch_target_buffer.sv | 92 +++++++++
 3 files changed

// File: rtl/branch_target_buffer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : branch_target_buffer_pkg                                         |
// | Brief    : Shared types, counter encodings and helper for the BTB           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package branch_target_buffer_pkg;

    localparam int XLEN          = 32;
    // Widest tag any legal table depth needs (ENTRIES=2); deeper tables zero-extend.
    localparam int BTB_TAG_MAX_W = XLEN - 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_MAX_W-1:0] tag;
        logic [XLEN-1:0]          target;
        logic [1:0]               ctr;
    } btb_entry_t;

    function automatic logic [1:0] btb_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_target_buffer_if.sv
// +----------------------------------------------------------------------------+
// | Module   : branch_target_buffer_if                                          |
// | Brief    : Fetch lookup and execute training signals of the BTB             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface branch_target_buffer_if;
    import branch_target_buffer_pkg::*;

    logic [XLEN-1:0] lookup_pc_i;
    logic            hit_o;
    logic [XLEN-1:0] target_o;
    logic            invalidate_i;
    logic            upd_en_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [XLEN-1:0] upd_target_i;

    modport master (
        output lookup_pc_i, invalidate_i, upd_en_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  hit_o, target_o
    );

    modport slave (
        input  lookup_pc_i, invalidate_i, upd_en_i, upd_pc_i, upd_taken_i, upd_target_i,
        output hit_o, target_o
    );

endinterface

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// +----------------------------------------------------------------------------+
// | Module   : branch_target_buffer                                             |
// | Brief    : Direct-mapped BTB, 2-bit counters, zero-latency lookup.          |
// |            Optional macro BTB_BYPASS_EN forwards same-index updates.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  wire                    clk_i,
    input  wire                    rst_i,
    branch_target_buffer_if.slave  bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 1;

    btb_entry_t r_table [ENTRIES];

    logic [IDX_W-1:0]         w_lk_idx;
    logic [BTB_TAG_MAX_W-1:0] w_lk_tag;
    logic [IDX_W-1:0]         w_upd_idx;
    logic [BTB_TAG_MAX_W-1:0] w_upd_tag;
    btb_entry_t               w_upd_old;
    btb_entry_t               w_upd_entry;
    logic                     w_upd_write;
    btb_entry_t               w_rd;
    logic                     w_unused_bits;

    // Bit 0 is never part of index or tag: compressed instructions are halfword aligned.
    assign w_unused_bits = bus.lookup_pc_i[0] ^ bus.upd_pc_i[0];

    assign w_lk_idx  = bus.lookup_pc_i[IDX_W:1];
    assign w_lk_tag  = BTB_TAG_MAX_W'(bus.lookup_pc_i[XLEN-1:IDX_W+1]);
    assign w_upd_idx = bus.upd_pc_i[IDX_W:1];
    assign w_upd_tag = BTB_TAG_MAX_W'(bus.upd_pc_i[XLEN-1:IDX_W+1]);
    assign w_upd_old = r_table[w_upd_idx];

    always_comb begin
        w_upd_entry = w_upd_old;
        w_upd_write = 1'b0;
        if (w_upd_old.valid && (w_upd_old.tag == w_upd_tag)) begin
            w_upd_write     = 1'b1;
            w_upd_entry.ctr = btb_ctr_next(w_upd_old.ctr, bus.upd_taken_i);
            if (bus.upd_taken_i) begin
                w_upd_entry.target = bus.upd_target_i;
            end
        end else if (bus.upd_taken_i) begin
            // Allocation evicts whatever occupied the slot.
            w_upd_write        = 1'b1;
            w_upd_entry.valid  = 1'b1;
            w_upd_entry.tag    = w_upd_tag;
            w_upd_entry.target = bus.upd_target_i;
            w_upd_entry.ctr    = CTR_WT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (bus.invalidate_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i].valid <= 1'b0;
            end
        end else if (bus.upd_en_i && w_upd_write) begin
            r_table[w_upd_idx] <= w_upd_entry;
        end
    end

`ifdef BTB_BYPASS_EN
    always_comb begin
        w_rd = r_table[w_lk_idx];
        if (bus.upd_en_i && !bus.invalidate_i && w_upd_write && (w_upd_idx == w_lk_idx)) begin
            w_rd = w_upd_entry;
        end
    end
`else
    assign w_rd = r_table[w_lk_idx];
`endif

    assign bus.hit_o    = w_rd.valid && (w_rd.tag == w_lk_tag) && w_rd.ctr[1];
    assign bus.target_o = bus.hit_o ? w_rd.target : '0;

endmodule

`default_nettype wire
